// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Pixel-coordinate and VGA sync timing generator. A tick divider derives the
// pixel rate from clk. Horizontal and vertical counters advance on each pixel
// tick. hsync, vsync and video_on are decoded from the counters and then
// delayed by SYNC_DLY clocks so they line up with a downstream pixel pipeline.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous reset, active-high
//   x           out  [10:0] horizontal count, 0..HT-1 (no added latency)
//   y           out  [10:0] vertical count, 0..VT-1 (no added latency)
//   p_tick      out  one-clk pulse every CLK_DIV clocks (pixel advance)
//   frame_start out  p_tick qualified with x == 0 and y == 0
//   hsync       out  horizontal sync, active-low, delayed SYNC_DLY clocks
//   vsync       out  vertical sync, active-low, delayed SYNC_DLY clocks
//   video_on    out  active display area, delayed SYNC_DLY clocks
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int HD       = 640,
    parameter int HF       = 16,
    parameter int HB       = 48,
    parameter int HR       = 96,
    parameter int VD       = 480,
    parameter int VF       = 10,
    parameter int VB       = 33,
    parameter int VR       = 2,
    parameter int SYNC_DLY = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        p_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on
);

    localparam int HT = HD + HF + HB + HR;
    localparam int VT = VD + VF + VB + VR;

    localparam logic [3:0]  DIV_LAST     = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST       = 11'(HT - 1);
    localparam logic [10:0] V_LAST       = 11'(VT - 1);
    localparam logic [10:0] H_DISP       = 11'(HD);
    localparam logic [10:0] V_DISP       = 11'(VD);
    localparam logic [10:0] H_SYNC_START = 11'(HD + HF);
    localparam logic [10:0] H_SYNC_END   = 11'(HD + HF + HR - 1);
    localparam logic [10:0] V_SYNC_START = 11'(VD + VF);
    localparam logic [10:0] V_SYNC_END   = 11'(VD + VF + VR - 1);

    // Idle value of a delay stage, packed as {hsync, vsync, video_on}.
    localparam logic [2:0]  STAGE_IDLE   = 3'b110;

    logic [3:0]  div_cnt_reg;
    logic [10:0] h_reg;
    logic [10:0] v_reg;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        vid_raw;
    logic [2:0]  raw_bus;

    // With CLK_DIV = 1 the divider sits at 0 == DIV_LAST, so p_tick is
    // permanently high.
    assign p_tick = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || p_tick) begin
            div_cnt_reg <= 4'd0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_reg <= 11'd0;
        end else if (p_tick) begin
            h_reg <= (h_reg == H_LAST) ? 11'd0 : h_reg + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_reg <= 11'd0;
        end else if (p_tick && (h_reg == H_LAST)) begin
            v_reg <= (v_reg == V_LAST) ? 11'd0 : v_reg + 11'd1;
        end
    end

    assign x           = h_reg;
    assign y           = v_reg;
    assign frame_start = p_tick && (h_reg == 11'd0) && (v_reg == 11'd0);

    assign hsync_raw = !((h_reg >= H_SYNC_START) && (h_reg <= H_SYNC_END));
    assign vsync_raw = !((v_reg >= V_SYNC_START) && (v_reg <= V_SYNC_END));
    assign vid_raw   = (h_reg < H_DISP) && (v_reg < V_DISP);
    assign raw_bus   = {hsync_raw, vsync_raw, vid_raw};

    // Delay line runs every clk (not on p_tick) so the latency is measured in
    // system clocks, matching the pixel pipeline it has to line up with.
    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign {hsync, vsync, video_on} = raw_bus;
        end else begin : g_dly
            for (genvar gi = 0; gi < SYNC_DLY; gi++) begin : g_stage
                logic [2:0] q_reg;
                logic [2:0] d;
                if (gi == 0) begin : g_first
                    assign d = raw_bus;
                end else begin : g_rest
                    assign d = g_stage[gi-1].q_reg;
                end
                always_ff @(posedge clk) begin
                    if (reset) begin
                        q_reg <= STAGE_IDLE;
                    end else begin
                        q_reg <= d;
                    end
                end
            end
            assign {hsync, vsync, video_on} = g_stage[SYNC_DLY-1].q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Directed bench for vga_sync_gen using three instances:
//   dut_a : default 640x480 timing, CLK_DIV = 4, SYNC_DLY = 2
//   dut_b : tiny timing (HT = 16, VT = 9), CLK_DIV = 2, SYNC_DLY = 1
//   dut_c : default timing, CLK_DIV = 1, SYNC_DLY = 0
// cyc counts clock edges since the active instance left reset; all samples
// are taken 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic reset_c = 1'b1;

    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic p_tick_a, frame_start_a, hsync_a, vsync_a, video_on_a;
    logic p_tick_b, frame_start_b, hsync_b, vsync_b, video_on_b;
    logic p_tick_c, frame_start_c, hsync_c, vsync_c, video_on_c;

    vga_sync_gen #(.CLK_DIV(4), .SYNC_DLY(2)) dut_a (
        .clk(clk), .reset(reset_a), .x(x_a), .y(y_a), .p_tick(p_tick_a),
        .frame_start(frame_start_a), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a)
    );

    vga_sync_gen #(.CLK_DIV(2), .HD(8), .HF(2), .HB(3), .HR(3),
                   .VD(4), .VF(1), .VB(2), .VR(2), .SYNC_DLY(1)) dut_b (
        .clk(clk), .reset(reset_b), .x(x_b), .y(y_b), .p_tick(p_tick_b),
        .frame_start(frame_start_b), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b)
    );

    vga_sync_gen #(.CLK_DIV(1), .SYNC_DLY(0)) dut_c (
        .clk(clk), .reset(reset_c), .x(x_c), .y(y_c), .p_tick(p_tick_c),
        .frame_start(frame_start_c), .hsync(hsync_c), .vsync(vsync_c),
        .video_on(video_on_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    int fs_count;
    int range_bad;
    int ptick_low;

    initial begin
        // ---------------- dut_a: default timing, CLK_DIV = 4 ----------------
        tick(); tick();
        reset_a = 1'b0;
        cyc = 0;
        check("a_reset_x",        x_a, 0);
        check("a_reset_y",        y_a, 0);
        check("a_reset_ptick",    p_tick_a, 0);
        check("a_reset_fstart",   frame_start_a, 0);
        check("a_reset_hsync",    hsync_a, 1);
        check("a_reset_vsync",    vsync_a, 1);
        check("a_reset_vid",      video_on_a, 0);
        goto(1);
        check("a_vid_c1",         video_on_a, 0);
        check("a_ptick_c1",       p_tick_a, 0);
        goto(2);
        check("a_vid_c2",         video_on_a, 1);
        goto(3);
        check("a_ptick_c3",       p_tick_a, 1);
        check("a_fstart_c3",      frame_start_a, 1);
        check("a_x_c3",           x_a, 0);
        goto(4);
        check("a_ptick_c4",       p_tick_a, 0);
        check("a_fstart_c4",      frame_start_a, 0);
        check("a_x_c4",           x_a, 1);
        goto(7);
        check("a_ptick_c7",       p_tick_a, 1);
        goto(2561);
        check("a_vid_c2561",      video_on_a, 1);
        goto(2562);
        check("a_x_c2562",        x_a, 640);
        check("a_vid_c2562",      video_on_a, 0);
        goto(2625);
        check("a_x_c2625",        x_a, 656);
        check("a_hsync_c2625",    hsync_a, 1);
        goto(2626);
        check("a_hsync_c2626",    hsync_a, 0);
        goto(3009);
        check("a_hsync_c3009",    hsync_a, 0);
        goto(3010);
        check("a_hsync_c3010",    hsync_a, 1);
        goto(3199);
        check("a_x_c3199",        x_a, 799);
        check("a_y_c3199",        y_a, 0);
        goto(3200);
        check("a_x_wrap",         x_a, 0);
        check("a_y_inc",          y_a, 1);

        // Reset in the middle of an hsync pulse on line 1 (x = 700).
        goto(6000);
        check("a_x_c6000",        x_a, 700);
        check("a_hsync_c6000",    hsync_a, 0);
        reset_a = 1'b1;
        tick();
        check("a_mid_rst_x",      x_a, 0);
        check("a_mid_rst_y",      y_a, 0);
        check("a_mid_rst_hsync",  hsync_a, 1);
        check("a_mid_rst_vsync",  vsync_a, 1);
        check("a_mid_rst_vid",    video_on_a, 0);
        reset_a = 1'b0;
        cyc = 0;
        tick();
        check("a_post_rst_hs1",   hsync_a, 1);
        check("a_post_rst_vid1",  video_on_a, 0);
        check("a_post_rst_pt1",   p_tick_a, 0);
        tick();
        check("a_post_rst_hs2",   hsync_a, 1);
        check("a_post_rst_vid2",  video_on_a, 1);
        reset_a = 1'b1;

        // ---------------- dut_b: tiny timing, HT=16 VT=9, CLK_DIV = 2 --------
        reset_b = 1'b0;
        cyc = 0;
        check("b_reset_ptick",    p_tick_b, 0);
        check("b_reset_vsync",    vsync_b, 1);
        goto(1);
        check("b_fstart_c1",      frame_start_b, 1);
        goto(21);
        check("b_x_c21",          x_b, 10);
        check("b_hsync_c21",      hsync_b, 0);
        goto(160);
        check("b_y_c160",         y_b, 5);
        check("b_vsync_c160",     vsync_b, 1);
        goto(161);
        check("b_vsync_c161",     vsync_b, 0);
        goto(224);
        check("b_vsync_c224",     vsync_b, 0);
        goto(225);
        check("b_vsync_c225",     vsync_b, 1);
        goto(287);
        check("b_x_c287",         x_b, 15);
        check("b_y_c287",         y_b, 8);
        goto(288);
        check("b_x_wrap",         x_b, 0);
        check("b_y_wrap",         y_b, 0);
        fs_count  = 0;
        range_bad = 0;
        goto(2);
        while (cyc < 577) begin
            if (frame_start_b) fs_count++;
            if (x_b > 11'd15 || y_b > 11'd8) range_bad++;
            tick();
        end
        check("b_fstart_per_frame", fs_count, 1);
        check("b_xy_range",       range_bad, 0);
        check("b_fstart_c577",    frame_start_b, 1);
        reset_b = 1'b1;

        // ---------------- dut_c: CLK_DIV = 1, SYNC_DLY = 0 -------------------
        reset_c = 1'b0;
        cyc = 0;
        check("c_ptick_c0",       p_tick_c, 1);
        check("c_fstart_c0",      frame_start_c, 1);
        ptick_low = 0;
        while (cyc < 655) begin
            tick();
            if (!p_tick_c) ptick_low++;
        end
        check("c_ptick_always",   ptick_low, 0);
        check("c_x_c655",         x_c, 655);
        check("c_hsync_c655",     hsync_c, 1);
        goto(656);
        check("c_hsync_c656",     hsync_c, 0);
        goto(751);
        check("c_hsync_c751",     hsync_c, 0);
        goto(752);
        check("c_x_c752",         x_c, 752);
        check("c_hsync_c752",     hsync_c, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
